// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame-controller state encoding, command layout and
// default fill byte, used by the SPI slave, master and register controller.
package spi_pkg;

  localparam int          ADDR_W        = 7;
  localparam int          CMD_RW_BIT    = 7;
  localparam logic [7:0]  FILL_BYTE_DEF = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RD_REQ,
    S_RD_CAP,
    S_DATA
  } spi_state_e;

  // Addresses above the top of the register bank alias to the top register.
  function automatic logic [ADDR_W-1:0] addr_clamp(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] addr_max);
    return (addr > addr_max) ? addr_max : addr;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_wrap_inc(input logic [ADDR_W-1:0] addr,
                                                      input logic [ADDR_W-1:0] addr_max);
    return (addr == addr_max) ? '0 : addr + 1'b1;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl.sv
// Frame-level SPI command decoder driving a single-port register bank.
// Define SPI_REG_AUTOINC_EN for burst addressing; otherwise the address is held per frame.
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_MAX  = 7'd127,
  parameter logic [7:0]        FILL_BYTE = FILL_BYTE_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cs,
  input  logic              byte_done,
  input  logic [7:0]        byte_rx,
  output logic [7:0]        byte_tx,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [7:0]        reg_wdata,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rdata,
  output logic              frame_active,
  output logic              err_overrun,
  input  logic              err_clr
);

  spi_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [7:0]        byte_tx_q, byte_tx_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              frame_q;

  function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] addr);
`ifdef SPI_REG_AUTOINC_EN
    return addr_wrap_inc(addr, ADDR_MAX);
`else
    return addr;
`endif
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    byte_tx_d = byte_tx_q;
    wr_en_d   = 1'b0;
    wdata_d   = wdata_q;
    err_d     = err_q;

    // Writes advance the address once the strobe cycle has presented it.
    if (wr_en_q) addr_d = addr_step(addr_q);

    unique case (state_q)
      S_IDLE: begin
        byte_tx_d = FILL_BYTE;
        if (!cs) state_d = S_CMD;
      end
      S_CMD: begin
        if (byte_done) begin
          rw_d    = byte_rx[CMD_RW_BIT];
          addr_d  = addr_clamp(byte_rx[ADDR_W-1:0], ADDR_MAX);
          state_d = byte_rx[CMD_RW_BIT] ? S_RD_REQ : S_DATA;
        end
      end
      S_RD_REQ: begin
        if (byte_done) err_d = 1'b1;
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        if (byte_done) err_d = 1'b1;
        byte_tx_d = reg_rdata;
        state_d   = S_DATA;
      end
      S_DATA: begin
        if (byte_done) begin
          if (rw_q) begin
            addr_d  = addr_step(addr_q);
            state_d = S_RD_REQ;
          end else begin
            wr_en_d = 1'b1;
            wdata_d = byte_rx;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte completing as cs rises is still decoded above; only the follow-on fetch is dropped.
    if (cs) begin
      state_d   = S_IDLE;
      byte_tx_d = FILL_BYTE;
    end

    if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      byte_tx_q <= FILL_BYTE;
      wr_en_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      byte_tx_q <= byte_tx_d;
      wr_en_q   <= wr_en_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      frame_q   <= !cs;
    end
  end

  assign byte_tx      = byte_tx_q;
  assign reg_addr     = addr_q;
  assign reg_wr_en    = wr_en_q;
  assign reg_wdata    = wdata_q;
  assign reg_rd_en    = (state_q == S_RD_REQ);
  assign frame_active = frame_q;
  assign err_overrun  = err_q;

endmodule
